// File: rtl/uart_axil_bridge_pkg.sv
// Shared types and constants for the UART to AXI4-Lite bridge: command FSM states,
// opcode/ack bytes and the AXI bus widths.
package uart_axil_bridge_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 64;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] ACK_BYTE = 8'h4B;

    typedef enum logic [2:0] {
        CMD_IDLE,
        CMD_ADDR,
        CMD_DATA,
        AXI_WR,
        AXI_WAIT_B,
        AXI_RD,
        AXI_WAIT_R,
        SEND_RESP
    } cmd_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_axil_bridge_if.sv
// AXI4-Lite bus (64-bit data) split into read and write channel modports,
// with initiator (mst) and target (slv) views of each.
interface axil_interface_if;
    import uart_axil_bridge_pkg::*;

    logic [AXI_ADDR_W-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [AXI_DATA_W-1:0]   wdata;
    logic [AXI_DATA_W/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic                    bvalid;
    logic                    bready;
    logic [AXI_ADDR_W-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [AXI_DATA_W-1:0]   rdata;
    logic                    rvalid;
    logic                    rready;

    modport wr_mst (output awaddr, awvalid, wdata, wstrb, wvalid, bready,
                    input  awready, wready, bvalid);
    modport wr_slv (input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
                    output awready, wready, bvalid);
    modport rd_mst (output araddr, arvalid, rready,
                    input  arready, rvalid, rdata);
    modport rd_slv (input  araddr, arvalid, rready,
                    output arready, rvalid, rdata);

endinterface

// File: rtl/uart_axil_bridge_phy.sv
// uart_byte_phy: 8N1 UART byte transceiver with rx synchronizer, mid-bit sampling
// receiver (valid pulse out) and a valid/ready transmitter that chains bytes gap-free.
module uart_byte_phy #(
    parameter int CLKS_PER_BIT = 72
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       tx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready
);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [BAUD_W-1:0] FULL = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_BITS, RX_WAIT_HIGH} rx_state_e;

    logic [1:0]        rx_sync;
    logic              rx_prev;
    rx_state_e         rx_state, rx_state_nxt;
    logic [BAUD_W-1:0] rx_baud;
    logic [3:0]        rx_bit;
    logic [7:0]        rx_shift;
    logic              rx_tick;

    logic [9:0]        tx_shift;
    logic              tx_active;
    logic [3:0]        tx_bit;
    logic [BAUD_W-1:0] tx_baud;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[0], rx};
            rx_prev <= rx_sync[1];
        end
    end

    assign rx_tick = (rx_baud == '0);

    // Bit index 0 is the start bit, 1..8 data, 9 the stop bit.
    always_comb begin
        rx_state_nxt = rx_state;
        case (rx_state)
            RX_IDLE:      if (rx_prev && !rx_sync[1]) rx_state_nxt = RX_BITS;
            RX_BITS: begin
                if (rx_tick) begin
                    if (rx_bit == 4'd0 && rx_sync[1])
                        rx_state_nxt = RX_IDLE;
                    else if (rx_bit == 4'd9)
                        rx_state_nxt = rx_sync[1] ? RX_IDLE : RX_WAIT_HIGH;
                end
            end
            RX_WAIT_HIGH: if (rx_sync[1]) rx_state_nxt = RX_IDLE;
            default:      rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_baud  <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_state <= rx_state_nxt;
            rx_valid <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    rx_baud <= HALF;
                    rx_bit  <= '0;
                end
                RX_BITS: begin
                    if (rx_tick) begin
                        rx_baud <= FULL;
                        rx_bit  <= rx_bit + 4'd1;
                        if (rx_bit >= 4'd1 && rx_bit <= 4'd8)
                            rx_shift <= {rx_sync[1], rx_shift[7:1]};
                        if (rx_bit == 4'd9 && rx_sync[1]) begin
                            rx_data  <= rx_shift;
                            rx_valid <= 1'b1;
                        end
                    end else begin
                        rx_baud <= rx_baud - BAUD_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Ready in the final cycle of a stop bit so the next start bit follows with no gap.
    assign tx_ready = !tx_active || (tx_baud == '0 && tx_bit == 4'd9);
    assign tx       = tx_shift[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift  <= '1;
            tx_active <= 1'b0;
            tx_bit    <= '0;
            tx_baud   <= '0;
        end else if (tx_valid && tx_ready) begin
            tx_shift  <= {1'b1, tx_data, 1'b0};
            tx_active <= 1'b1;
            tx_bit    <= '0;
            tx_baud   <= FULL;
        end else if (tx_active) begin
            if (tx_baud == '0) begin
                tx_baud <= FULL;
                if (tx_bit == 4'd9) begin
                    tx_active <= 1'b0;
                end else begin
                    tx_shift <= {1'b1, tx_shift[9:1]};
                    tx_bit   <= tx_bit + 4'd1;
                end
            end else begin
                tx_baud <= tx_baud - BAUD_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_axil_bridge.sv
// UART command bridge to AXI4-Lite: 'W' addr data -> write + ack 0x4B, 'R' addr -> read
// + 8 data bytes. Define UART_AXIL_BRIDGE_TIMEOUT_EN to abort stalled commands.
module uart_axil_bridge
    import uart_axil_bridge_pkg::*;
#(
    parameter int CLOCK_FREQ_OVER_BAUD_RATE = 72,
    parameter int ADDR_BYTES                = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    output logic              tx,
    axil_interface_if.rd_mst  read_access,
    axil_interface_if.wr_mst  write_access,
    output logic              busy
);
    localparam int CNT_W  = $clog2(max_int(ADDR_BYTES, 8) + 1);
    localparam int ASEL_W = $clog2(AXI_ADDR_W / 8);
    localparam logic [CNT_W-1:0] LAST_ADDR  = CNT_W'(ADDR_BYTES - 1);
    localparam logic [CNT_W-1:0] LAST_DATA  = CNT_W'(7);
    localparam logic [CNT_W-1:0] ADDR_SLOTS = CNT_W'(AXI_ADDR_W / 8);

    cmd_state_e            state, state_nxt;
    logic [7:0]            rx_byte;
    logic                  rx_valid;
    logic [7:0]            tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [CNT_W-1:0]      byte_cnt;
    logic                  is_write;
    logic [AXI_ADDR_W-1:0] addr_q;
    logic [AXI_DATA_W-1:0] data_q;
    logic [AXI_DATA_W-1:0] resp_q;
    logic [CNT_W-1:0]      resp_len;
    logic [CNT_W-1:0]      resp_cnt;
    logic                  aw_done, w_done;
    logic                  aw_hs, w_hs;
    logic                  timeout;

    uart_byte_phy #(.CLKS_PER_BIT(CLOCK_FREQ_OVER_BAUD_RATE)) u_phy (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .tx       (tx),
        .rx_data  (rx_byte),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    assign busy = (state != CMD_IDLE);

    assign write_access.awvalid = (state == AXI_WR) && !aw_done;
    assign write_access.wvalid  = (state == AXI_WR) && !w_done;
    assign write_access.awaddr  = addr_q;
    assign write_access.wdata   = data_q;
    assign write_access.wstrb   = '1;
    assign write_access.bready  = (state == AXI_WAIT_B);
    assign read_access.arvalid  = (state == AXI_RD);
    assign read_access.araddr   = addr_q;
    assign read_access.rready   = (state == AXI_WAIT_R);

    assign aw_hs = write_access.awvalid && write_access.awready;
    assign w_hs  = write_access.wvalid && write_access.wready;

    assign tx_valid = (state == SEND_RESP) && (resp_cnt != resp_len);
    assign tx_data  = resp_q[{resp_cnt[2:0], 3'b000} +: 8];

`ifdef UART_AXIL_BRIDGE_TIMEOUT_EN
    localparam int TO_CYCLES = 1024 * CLOCK_FREQ_OVER_BAUD_RATE;
    localparam int TO_W      = $clog2(TO_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;

    // Idle time is only counted while a command is partially received.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            to_cnt <= '0;
        else if (rx_valid || !(state == CMD_ADDR || state == CMD_DATA))
            to_cnt <= '0;
        else if (!timeout)
            to_cnt <= to_cnt + TO_W'(1);
    end

    assign timeout = (to_cnt == TO_W'(TO_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= CMD_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CMD_IDLE:
                if (rx_valid && (rx_byte == OP_WRITE || rx_byte == OP_READ))
                    state_nxt = CMD_ADDR;
            CMD_ADDR:
                if (timeout)
                    state_nxt = CMD_IDLE;
                else if (rx_valid && byte_cnt == LAST_ADDR)
                    state_nxt = is_write ? CMD_DATA : AXI_RD;
            CMD_DATA:
                if (timeout)
                    state_nxt = CMD_IDLE;
                else if (rx_valid && byte_cnt == LAST_DATA)
                    state_nxt = AXI_WR;
            AXI_WR:
                if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = AXI_WAIT_B;
            AXI_WAIT_B: if (write_access.bvalid) state_nxt = SEND_RESP;
            AXI_RD:     if (read_access.arready) state_nxt = AXI_WAIT_R;
            AXI_WAIT_R: if (read_access.rvalid)  state_nxt = SEND_RESP;
            SEND_RESP:  if (resp_cnt == resp_len && tx_ready) state_nxt = CMD_IDLE;
            default:    state_nxt = CMD_IDLE;
        endcase
    end

    // Command bytes arrive little-endian; address bytes beyond the bus width are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= '0;
            is_write <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            resp_q   <= '0;
            resp_len <= '0;
            resp_cnt <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            case (state)
                CMD_IDLE: begin
                    if (rx_valid) begin
                        is_write <= (rx_byte == OP_WRITE);
                        byte_cnt <= '0;
                        addr_q   <= '0;
                        aw_done  <= 1'b0;
                        w_done   <= 1'b0;
                    end
                end
                CMD_ADDR: begin
                    if (rx_valid) begin
                        if (byte_cnt < ADDR_SLOTS)
                            addr_q[{byte_cnt[ASEL_W-1:0], 3'b000} +: 8] <= rx_byte;
                        byte_cnt <= (byte_cnt == LAST_ADDR) ? '0 : byte_cnt + CNT_W'(1);
                    end
                end
                CMD_DATA: begin
                    if (rx_valid) begin
                        data_q[{byte_cnt[2:0], 3'b000} +: 8] <= rx_byte;
                        byte_cnt <= byte_cnt + CNT_W'(1);
                    end
                end
                AXI_WR: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                end
                AXI_WAIT_B: begin
                    if (write_access.bvalid) begin
                        resp_q   <= {{(AXI_DATA_W-8){1'b0}}, ACK_BYTE};
                        resp_len <= CNT_W'(1);
                        resp_cnt <= '0;
                    end
                end
                AXI_WAIT_R: begin
                    if (read_access.rvalid) begin
                        resp_q   <= read_access.rdata;
                        resp_len <= CNT_W'(8);
                        resp_cnt <= '0;
                    end
                end
                SEND_RESP: begin
                    if (tx_valid && tx_ready) resp_cnt <= resp_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_axil_bridge.sv
// Directed + randomized bench for uart_axil_bridge: UART byte driver/decoder, random-ready
// AXI-Lite target, expectations computed from command values (UART_AXIL_BRIDGE_TIMEOUT_EN aware).
module tb_uart_axil_bridge;
    import uart_axil_bridge_pkg::*;

    localparam int CLKS       = 16;
    localparam int ADDR_BYTES = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx    = 1'b1;
    logic tx;
    logic busy;

    axil_interface_if axil ();

    uart_axil_bridge #(
        .CLOCK_FREQ_OVER_BAUD_RATE (CLKS),
        .ADDR_BYTES                (ADDR_BYTES)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (rx),
        .tx           (tx),
        .read_access  (axil.rd_mst),
        .write_access (axil.wr_mst),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int          vectors    = 0;
    int          miscompares = 0;
    longint      cyc        = 0;
    logic [31:0] aw_q[$];
    logic [31:0] ar_q[$];
    logic [63:0] w_q[$];
    logic [7:0]  strb_q[$];
    logic [7:0]  tx_q[$];
    longint      tx_start_q[$];
    logic [7:0]  stim_q[$];
    int          aw_hs_cnt = 0, ar_hs_cnt = 0, proto_err = 0, tx_frame_err = 0;
    bit          aw_seen = 0, w_seen = 0, b_pend = 0, r_pend = 0;
    bit          ar_block = 0, b_block = 0;
    logic [63:0] r_data = '0, rd_value = '0;
    longint      aw_rise = 0, w_rise = 0;
    logic        aw_prev = 1'b0, w_prev = 1'b0;

    // Target-side bookkeeping of every handshake seen on the bus
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            aw_seen = 0; w_seen = 0; b_pend = 0; r_pend = 0;
        end else begin
            if (axil.awvalid && axil.awready) begin aw_q.push_back(axil.awaddr); aw_seen = 1; aw_hs_cnt++; end
            if (axil.wvalid && axil.wready) begin w_q.push_back(axil.wdata); strb_q.push_back(axil.wstrb); w_seen = 1; end
            if (aw_seen && w_seen) begin b_pend = 1; aw_seen = 0; w_seen = 0; end
            if (axil.bvalid && axil.bready) b_pend = 0;
            if (axil.arvalid && axil.arready) begin ar_q.push_back(axil.araddr); ar_hs_cnt++; r_pend = 1; r_data = rd_value; end
            if (axil.rvalid && axil.rready) r_pend = 0;
            if (axil.arvalid && (axil.awvalid || axil.wvalid)) proto_err++;
            if (!busy && (axil.arvalid || axil.awvalid || axil.wvalid)) proto_err++;
        end
        if (axil.awvalid && !aw_prev) aw_rise = cyc;
        if (axil.wvalid && !w_prev) w_rise = cyc;
        aw_prev = axil.awvalid;
        w_prev  = axil.wvalid;
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                axil.awready = 0; axil.wready = 0; axil.arready = 0;
                axil.bvalid = 0; axil.rvalid = 0; axil.rdata = '0;
            end else begin
                axil.awready = 1'($urandom_range(0, 1));
                axil.wready  = 1'($urandom_range(0, 1));
                axil.arready = ar_block ? 1'b0 : 1'($urandom_range(0, 1));
                axil.bvalid  = b_pend && !b_block && (axil.bvalid || 1'($urandom_range(0, 1)));
                axil.rvalid  = r_pend && (axil.rvalid || 1'($urandom_range(0, 1)));
                axil.rdata   = r_data;
            end
        end
    end

    // UART decoder on tx, records the byte and the cycle its start bit began
    initial begin
        logic [7:0] b;
        longint     st;
        forever begin
            @(negedge tx);
            st = cyc;
            repeat (CLKS / 2) @(posedge clk);
            #1;
            if (tx !== 1'b0) continue;
            for (int i = 0; i < 8; i++) begin
                repeat (CLKS) @(posedge clk);
                #1;
                b[i] = tx;
            end
            repeat (CLKS) @(posedge clk);
            #1;
            if (tx !== 1'b1) tx_frame_err++;
            tx_q.push_back(b);
            tx_start_q.push_back(st);
        end
    end

    initial begin
        #(150000 * 10);
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        @(negedge clk) rx = 1'b0;
        repeat (CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CLKS) @(negedge clk);
        end
        rx = stop_ok;
        repeat (CLKS) @(negedge clk);
        rx = 1'b1;
        if (!stop_ok) repeat (CLKS) @(negedge clk);
    endtask

    task automatic applyStimulus();
        foreach (stim_q[i]) send_frame(stim_q[i], 1'b1);
    endtask

    task automatic build_cmd(input logic [7:0] op, input logic [31:0] a, input logic [63:0] d);
        stim_q = {};
        stim_q.push_back(op);
        for (int i = 0; i < ADDR_BYTES; i++) stim_q.push_back(8'((a >> (8 * i)) & 32'hFF));
        if (op == OP_WRITE)
            for (int i = 0; i < 8; i++) stim_q.push_back(8'((d >> (8 * i)) & 64'hFF));
    endtask

    task automatic clear_logs();
        aw_q = {}; w_q = {}; strb_q = {}; ar_q = {}; tx_q = {}; tx_start_q = {};
    endtask

    task automatic wait_tx(input string tag, input int n);
        int budget = (n * 10 + 20) * CLKS + 500;
        while (tx_q.size() < n && budget > 0) begin @(negedge clk); budget--; end
        checkOutput({tag, "_tx_count"}, 64'(tx_q.size()), 64'(n));
    endtask

    task automatic wait_idle(input string tag);
        int budget = 4 * CLKS + 100;
        while (busy && budget > 0) begin @(negedge clk); budget--; end
        checkOutput({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        checkOutput(tag, 64'({tx, busy, axil.awvalid, axil.wvalid, axil.arvalid, axil.bready, axil.rready}),
                    64'(7'b1000000));
    endtask

    task automatic do_write(input string tag, input logic [31:0] a, input logic [63:0] d);
        int n_aw = aw_hs_cnt;
        clear_logs();
        build_cmd(OP_WRITE, a, d);
        applyStimulus();
        wait_tx(tag, 1);
        checkOutput({tag, "_ack"}, (tx_q.size() > 0) ? 64'(tx_q[0]) : 'x, 64'(ACK_BYTE));
        wait_idle(tag);
        checkOutput({tag, "_aw_hs"}, 64'(aw_hs_cnt - n_aw), 64'd1);
        checkOutput({tag, "_awaddr"}, (aw_q.size() > 0) ? 64'(aw_q[0]) : 'x, 64'(a));
        checkOutput({tag, "_wdata"}, (w_q.size() > 0) ? w_q[0] : 'x, d);
        checkOutput({tag, "_wstrb"}, (strb_q.size() > 0) ? 64'(strb_q[0]) : 'x, 64'h00FF);
        checkOutput({tag, "_aw_w_same_cycle"}, 64'(aw_rise), 64'(w_rise));
    endtask

    task automatic check_read_response(input string tag, input logic [31:0] a, input logic [63:0] v);
        wait_tx(tag, 8);
        for (int i = 0; i < 8 && i < tx_q.size(); i++)
            checkOutput($sformatf("%s_byte%0d", tag, i), 64'(tx_q[i]), (v >> (8 * i)) & 64'hFF);
        for (int i = 1; i < 8 && i < tx_start_q.size(); i++)
            checkOutput($sformatf("%s_gap%0d", tag, i), 64'(tx_start_q[i] - tx_start_q[i-1]), 64'(10 * CLKS));
        checkOutput({tag, "_araddr"}, (ar_q.size() > 0) ? 64'(ar_q[0]) : 'x, 64'(a));
        wait_idle(tag);
    endtask

    task automatic do_read(input string tag, input logic [31:0] a, input logic [63:0] v);
        clear_logs();
        rd_value = v;
        build_cmd(OP_READ, a, '0);
        applyStimulus();
        check_read_response(tag, a, v);
    endtask

    initial begin
        int          budget;
        int          n_ar, n_aw;
        logic [31:0] a;
        logic [63:0] v;

        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check_idle_outputs("reset_values");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        $display("[TB] directed write and read");
        do_write("wr_directed", 32'h0000_1000, 64'h0807_0605_0403_0201);
        do_read("rd_directed", 32'h0000_0018, 64'h1122_3344_5566_7788);

        for (int k = 0; k < 2; k++) begin
            do_write($sformatf("wr_rand%0d", k), $urandom, {$urandom, $urandom});
            do_read($sformatf("rd_rand%0d", k), $urandom, {$urandom, $urandom});
        end

        $display("[TB] read address backpressure");
        clear_logs();
        n_ar = ar_hs_cnt;
        a = $urandom;
        v = {$urandom, $urandom};
        rd_value = v;
        ar_block = 1;
        build_cmd(OP_READ, a, '0);
        applyStimulus();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("bp_arvalid%0d", i), 64'(axil.arvalid), 64'd1);
            checkOutput($sformatf("bp_araddr%0d", i), 64'(axil.araddr), 64'(a));
        end
        ar_block = 0;
        check_read_response("bp", a, v);
        checkOutput("bp_ar_hs", 64'(ar_hs_cnt - n_ar), 64'd1);

        $display("[TB] framing error and junk byte");
        send_frame(OP_WRITE, 1'b0);
        repeat (2 * CLKS) @(negedge clk);
        checkOutput("bad_stop_busy", 64'(busy), 64'd0);
        send_frame(8'h41, 1'b1);
        repeat (2 * CLKS) @(negedge clk);
        checkOutput("junk_busy", 64'(busy), 64'd0);
        do_read("rd_after_frame", $urandom, {$urandom, $urandom});

        $display("[TB] reset during command data");
        clear_logs();
        n_aw = aw_hs_cnt;
        build_cmd(OP_WRITE, 32'hDEAD_BEE0, 64'h0123_4567_89AB_CDEF);
        for (int i = 0; i < 1 + ADDR_BYTES + 3; i++) send_frame(stim_q[i], 1'b1);
        checkOutput("rst_data_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("rst_data_outputs");
        rst_n = 1'b1;
        repeat (4 * CLKS) @(negedge clk);
        checkOutput("rst_data_no_aw", 64'(aw_hs_cnt - n_aw), 64'd0);
        do_write("wr_after_rst_data", $urandom, {$urandom, $urandom});

        $display("[TB] reset while waiting for write response");
        clear_logs();
        b_block = 1;
        build_cmd(OP_WRITE, $urandom, {$urandom, $urandom});
        applyStimulus();
        budget = 200;
        while (!axil.bready && budget > 0) begin @(negedge clk); budget--; end
        checkOutput("rst_wb_reached", 64'(axil.bready), 64'd1);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("rst_wb_outputs");
        rst_n = 1'b1;
        b_block = 0;
        repeat (12 * CLKS) @(negedge clk);
        checkOutput("rst_wb_no_tx", 64'(tx_q.size()), 64'd0);
        do_write("wr_after_rst_wb", $urandom, {$urandom, $urandom});

`ifdef UART_AXIL_BRIDGE_TIMEOUT_EN
        $display("[TB] partial command timeout");
        stim_q = {OP_WRITE, 8'h00};
        applyStimulus();
        checkOutput("to_busy_start", 64'(busy), 64'd1);
        budget = 0;
        while (busy && budget < 1100 * CLKS) begin @(negedge clk); budget++; end
        checkOutput("to_window", 64'(budget >= 1022 * CLKS && budget <= 1026 * CLKS), 64'd1);
        do_read("rd_after_timeout", $urandom, {$urandom, $urandom});
`endif

        checkOutput("protocol_violations", 64'(proto_err), 64'd0);
        checkOutput("tx_framing", 64'(tx_frame_err), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_axil_bridge.md
UART_AXIL_BRIDGE -- requirements
Module: uart_axil_bridge

Interface
REQ-001 Parameter: CLOCK_FREQ_OVER_BAUD_RATE, default 72, clk cycles per UART bit.
REQ-002 Parameter: ADDR_BYTES, default 4, address bytes per command (little-endian).
REQ-003 Port: clk  input  1  sole clock; all state on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: rx  input  1  UART receive pin, asynchronous to clk.
REQ-006 Port: tx  output  1  UART transmit pin.
REQ-007 Port: read_access  axil_interface_if.rd_mst  --  AXI4-Lite read initiator, 64-bit rdata.
REQ-008 Port: write_access  axil_interface_if.wr_mst  --  AXI4-Lite write initiator, 64-bit wdata.
REQ-009 Port: busy  output  1  high whenever the command FSM is not in CMD_IDLE.

Function
REQ-010 Framing SHALL be 8N1, LSB first; tx idles high.
REQ-011 rx SHALL pass a 2-flop synchronizer before use.
REQ-012 The receiver SHALL detect a falling edge, then sample each bit at mid-period (CLOCK_FREQ_OVER_BAUD_RATE/2 after the edge, then every CLOCK_FREQ_OVER_BAUD_RATE cycles).
REQ-013 A byte whose stop bit samples 0 SHALL be discarded; the receiver then waits for rx high before re-arming.
REQ-014 The command FSM states SHALL be: CMD_IDLE, CMD_ADDR, CMD_DATA, AXI_WR, AXI_WAIT_B, AXI_RD, AXI_WAIT_R, SEND_RESP.
REQ-015 From CMD_IDLE: byte 0x57 ('W') or 0x52 ('R') -> CMD_ADDR; any other byte is ignored and the FSM stays in CMD_IDLE.
REQ-016 CMD_ADDR: after ADDR_BYTES bytes, 'W' -> CMD_DATA and 'R' -> AXI_RD; the address is zero-extended to the interface address width.
REQ-017 CMD_DATA: after 8 bytes (little-endian) -> AXI_WR.
REQ-018 AXI_WR: awvalid and wvalid SHALL assert in the same cycle.
REQ-019 AXI_WR: each valid drops independently on its own handshake; awaddr and wdata stay stable until then.
REQ-020 AXI_WR: wstrb SHALL be 0xFF.
REQ-021 AXI_WR: when both handshakes are complete -> AXI_WAIT_B.
REQ-022 AXI_WAIT_B: bready=1; on bvalid -> SEND_RESP with response byte 0x4B.
REQ-023 AXI_RD: arvalid=1 with araddr stable until arready -> AXI_WAIT_R.
REQ-024 AXI_WAIT_R: rready=1; on rvalid, capture rdata -> SEND_RESP with 8 bytes, LSB byte first.
REQ-025 SEND_RESP: bytes are transmitted back-to-back with no idle bit gaps; after the last stop bit -> CMD_IDLE.
REQ-026 Bytes received outside CMD_IDLE/CMD_ADDR/CMD_DATA SHALL be dropped.
REQ-027 Only one AXI transaction SHALL be outstanding at a time; no valid is asserted outside AXI_WR/AXI_RD.
REQ-028 Byte counters SHALL be sized $clog2 of max(ADDR_BYTES, 8)+1 with no wrap.

Reset
REQ-029 Reset SHALL return all FSMs to idle.
REQ-030 Reset values: tx=1, busy=0, and all valid/ready outputs 0.
REQ-031 Reset mid-transaction SHALL abandon the transaction; responses after reset release are ignored.

Configuration
REQ-032 With UART_AXIL_BRIDGE_TIMEOUT_EN defined: if no byte completes within 1024*CLOCK_FREQ_OVER_BAUD_RATE cycles while in CMD_ADDR or CMD_DATA, the FSM returns to CMD_IDLE and discards partial data.
REQ-033 With UART_AXIL_BRIDGE_TIMEOUT_EN undefined: no timeout counter exists and the FSM waits indefinitely.

Structure
REQ-034 Package uart_axil_bridge_pkg SHALL hold the cmd_state_e typedef and the opcode/ack constants (0x57, 0x52, 0x4B).
REQ-035 Sub-module uart_byte_phy SHALL implement the synchronizer, RX/TX shifters and bit timing.
REQ-036 uart_byte_phy byte interfaces: valid pulse for received bytes; valid/ready for transmit.

Verification
REQ-037 Write: rx 57 00 10 00 00 01 02 03 04 05 06 07 08 -> awaddr=0x1000, wdata=0x0807060504030201, wstrb=0xFF; after bvalid, tx sends 0x4B.
REQ-038 Read: rx 52 18 00 00 00, slave returns 0x1122334455667788 -> tx sends 88 77 66 55 44 33 22 11.
REQ-039 Backpressure: hold arready low 5 cycles -> arvalid stays high and araddr stays stable; exactly one handshake occurs.
REQ-040 Framing: rx byte 0x57 with stop bit 0 -> discarded, busy stays 0; a subsequent valid command is processed normally.
REQ-041 Reset: rst_n low during CMD_DATA and during AXI_WAIT_B -> tx=1, busy=0, all valids 0; the next command is processed normally.
REQ-042 Timeout (macro on): 57 00 then silence -> busy falls after 1024 bit periods; a following 52 command is processed.
